// File: rtl/tank_hit_responder.sv
// tank_hit_responder: decides each frame whether the opponent's bullet struck
// this tank, and owns the tank's health, armor and invulnerability state.
module tank_hit_responder #(
  parameter logic [1:0] Lives_Init    = 2'd3,
  parameter logic [1:0] Armor_Max     = 2'd2,
  parameter logic [6:0] Invuln_Frames = 7'd60
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic [9:0] BulletX,
  input  logic [9:0] BulletY,
  input  logic [9:0] BulletS,
  input  logic       bullet_on,
  input  logic       bullet_upgraded,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [9:0] TankS,
  input  logic       armor_pickup,
  input  logic       restart,
  output logic       player_hit,
  output logic       armor_hit,
  output logic [1:0] health,
  output logic [1:0] armor_count,
  output logic       invuln,
  output logic       player_dead
);

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_INVULN = 2'd1,
    ST_DEAD   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] health_q, health_d;
  logic [1:0] armor_q, armor_d;
  logic [6:0] cnt_q, cnt_d;
  logic       player_hit_q, player_hit_d;
  logic       armor_hit_q, armor_hit_d;
  logic       overlap_q, overlap_d;

  logic [10:0] dx;
  logic [10:0] dy;
  logic [10:0] r;
  logic        hit_evt;
  logic [1:0]  health_dec;

  // Box overlap test on 11-bit magnitudes so the sum of half-sizes cannot wrap.
  always_comb begin
    dx = (BulletX >= TankX) ? ({1'b0, BulletX} - {1'b0, TankX})
                            : ({1'b0, TankX} - {1'b0, BulletX});
    dy = (BulletY >= TankY) ? ({1'b0, BulletY} - {1'b0, TankY})
                            : ({1'b0, TankY} - {1'b0, BulletY});
    r  = {1'b0, BulletS} + {1'b0, TankS};
    overlap_d = bullet_on & (dx <= r) & (dy <= r);
    // Rising edge of overlap only, so a lingering bullet counts once.
    hit_evt   = overlap_d & ~overlap_q;
  end

  // Next-state, counter, health/armor and pulse decisions.
  always_comb begin
    state_d      = state_q;
    health_d     = health_q;
    armor_d      = armor_q;
    cnt_d        = cnt_q;
    player_hit_d = 1'b0;
    armor_hit_d  = 1'b0;
    health_dec   = (health_q != 2'd0) ? (health_q - 2'd1) : 2'd0;

    if (restart) begin
      state_d  = ST_ALIVE;
      health_d = Lives_Init;
      armor_d  = 2'd0;
      cnt_d    = 7'd0;
    end else begin
      case (state_q)
        ST_ALIVE: begin
          if (hit_evt) begin
            if (armor_q != 2'd0) begin
              armor_hit_d = 1'b1;
              armor_d     = bullet_upgraded ? 2'd0 : (armor_q - 2'd1);
            end else begin
              player_hit_d = 1'b1;
              health_d     = health_dec;
              if (health_dec == 2'd0) begin
                state_d = ST_DEAD;
              end else begin
                state_d = ST_INVULN;
                cnt_d   = Invuln_Frames - 7'd1;
              end
            end
          end
        end
        ST_INVULN: begin
          // Bullet is still consumed, but the tank takes no damage.
          if (hit_evt) begin
            player_hit_d = 1'b1;
          end
          if (cnt_q == 7'd0) begin
            state_d = ST_ALIVE;
          end else begin
            cnt_d = cnt_q - 7'd1;
          end
        end
        ST_DEAD: begin
          // Bullets pass through; wait for restart.
        end
        default: begin
          state_d = ST_ALIVE;
        end
      endcase

      // Pickup wins over a same-frame hit; the hit already used the old armor.
      if (armor_pickup && (state_q != ST_DEAD)) begin
        armor_d = Armor_Max;
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_ALIVE;
      health_q     <= Lives_Init;
      armor_q      <= 2'd0;
      cnt_q        <= 7'd0;
      player_hit_q <= 1'b0;
      armor_hit_q  <= 1'b0;
      overlap_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      health_q     <= health_d;
      armor_q      <= armor_d;
      cnt_q        <= cnt_d;
      player_hit_q <= player_hit_d;
      armor_hit_q  <= armor_hit_d;
      overlap_q    <= overlap_d;
    end
  end

  assign player_hit  = player_hit_q;
  assign armor_hit   = armor_hit_q;
  assign health      = health_q;
  assign armor_count = armor_q;
  assign invuln      = (state_q == ST_INVULN);
  assign player_dead = (state_q == ST_DEAD);

endmodule

// File: tb/tb_tank_hit_responder.sv
// Directed testbench for tank_hit_responder.
module tb_tank_hit_responder;

  logic       frame_clk;
  logic       Reset_n;
  logic [9:0] BulletX, BulletY, BulletS;
  logic       bullet_on, bullet_upgraded;
  logic [9:0] TankX, TankY, TankS;
  logic       armor_pickup, restart;
  logic       player_hit, armor_hit;
  logic [1:0] health, armor_count;
  logic       invuln, player_dead;

  int checks;
  int failures;

  tank_hit_responder dut (
    .frame_clk      (frame_clk),
    .Reset_n        (Reset_n),
    .BulletX        (BulletX),
    .BulletY        (BulletY),
    .BulletS        (BulletS),
    .bullet_on      (bullet_on),
    .bullet_upgraded(bullet_upgraded),
    .TankX          (TankX),
    .TankY          (TankY),
    .TankS          (TankS),
    .armor_pickup   (armor_pickup),
    .restart        (restart),
    .player_hit     (player_hit),
    .armor_hit      (armor_hit),
    .health         (health),
    .armor_count    (armor_count),
    .invuln         (invuln),
    .player_dead    (player_dead)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // Advance one frame; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic bullet(input int x, input int y, input int s, input logic on);
    BulletX = 10'(x); BulletY = 10'(y); BulletS = 10'(s); bullet_on = on;
  endtask

  task automatic hit_now();   // overlapping bullet centred on the tank
    bullet(100, 100, 2, 1'b1);
  endtask

  task automatic do_restart();
    bullet(300, 300, 2, 1'b0);
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    #12;
    checks++; if (health !== 2'd3) begin failures++; $display("FAIL reset_health got=%0d exp=3", health); end
    checks++; if (armor_count !== 2'd0) begin failures++; $display("FAIL reset_armor got=%0d exp=0", armor_count); end
    checks++; if ({player_hit, armor_hit, invuln, player_dead} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {player_hit, armor_hit, invuln, player_dead}); end
    Reset_n = 1'b1;
    tick();
    $display("reset: health=%0d armor=%0d", health, armor_count);
  endtask

  task automatic test_approach();
    int bad;
    do_restart();
    bullet(112, 100, 2, 1'b1);
    tick();
    checks++; if (player_hit !== 1'b0) begin failures++; $display("FAIL approach_far_hit got=%b exp=0", player_hit); end
    bullet(108, 100, 2, 1'b1);
    tick();
    checks++; if (player_hit !== 1'b1) begin failures++; $display("FAIL approach_hit got=%b exp=1", player_hit); end
    checks++; if (health !== 2'd2) begin failures++; $display("FAIL approach_health got=%0d exp=2", health); end
    checks++; if (invuln !== 1'b1) begin failures++; $display("FAIL approach_invuln got=%b exp=1", invuln); end
    bullet(300, 300, 2, 1'b0);
    tick();   // edge N+1
    checks++; if (player_hit !== 1'b0) begin failures++; $display("FAIL approach_pulse_clear got=%b exp=0", player_hit); end
    bad = 0;
    for (int k = 2; k <= 59; k++) begin
      tick();
      if (invuln !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL approach_invuln_hold low_frames=%0d exp=0", bad); end
    tick();   // edge N+60
    checks++; if (invuln !== 1'b0) begin failures++; $display("FAIL approach_invuln_expire got=%b exp=0", invuln); end
    $display("approach: health=%0d invuln=%b", health, invuln);
  endtask

  task automatic test_boundary();
    do_restart();
    bullet(110, 100, 2, 1'b1);   // dx == r
    tick();
    checks++; if (armor_hit !== 1'b0 || player_hit !== 1'b1) begin failures++; $display("FAIL bound_dx_eq got=%b exp=1", player_hit); end
    do_restart();
    bullet(100, 111, 2, 1'b1);   // dy == r+1
    tick();
    checks++; if (player_hit !== 1'b0) begin failures++; $display("FAIL bound_dy_over got=%b exp=0", player_hit); end
    do_restart();
    bullet(100, 90, 2, 1'b1);    // bullet above tank, dy == r
    tick();
    checks++; if (player_hit !== 1'b1) begin failures++; $display("FAIL bound_dy_neg got=%b exp=1", player_hit); end
    do_restart();
    bullet(100, 100, 2, 1'b0);   // overlapping but not live
    tick();
    checks++; if (player_hit !== 1'b0) begin failures++; $display("FAIL bound_not_live got=%b exp=0", player_hit); end
    $display("boundary: done");
  endtask

  task automatic test_armor();
    do_restart();
    armor_pickup = 1'b1;
    tick();
    armor_pickup = 1'b0;
    checks++; if (armor_count !== 2'd2) begin failures++; $display("FAIL armor_pickup got=%0d exp=2", armor_count); end
    hit_now(); bullet_upgraded = 1'b0;
    tick();
    checks++; if (armor_hit !== 1'b1 || player_hit !== 1'b0) begin failures++; $display("FAIL armor_normal_pulse got=%b%b exp=10", armor_hit, player_hit); end
    checks++; if (armor_count !== 2'd1) begin failures++; $display("FAIL armor_normal_count got=%0d exp=1", armor_count); end
    bullet(300, 300, 2, 1'b0);
    tick();
    checks++; if (armor_hit !== 1'b0) begin failures++; $display("FAIL armor_pulse_clear got=%b exp=0", armor_hit); end
    hit_now(); bullet_upgraded = 1'b1;
    tick();
    checks++; if (armor_hit !== 1'b1 || armor_count !== 2'd0) begin failures++; $display("FAIL armor_upg_1 got=%b/%0d exp=1/0", armor_hit, armor_count); end
    bullet(300, 300, 2, 1'b0);
    armor_pickup = 1'b1;
    tick();
    armor_pickup = 1'b0;
    hit_now();
    tick();
    checks++; if (armor_hit !== 1'b1 || armor_count !== 2'd0) begin failures++; $display("FAIL armor_upg_2 got=%b/%0d exp=1/0", armor_hit, armor_count); end
    bullet_upgraded = 1'b0;
    checks++; if (health !== 2'd3) begin failures++; $display("FAIL armor_health got=%0d exp=3", health); end
    $display("armor: armor=%0d health=%0d", armor_count, health);
  endtask

  task automatic test_invuln();
    do_restart();
    hit_now();
    tick();                            // edge N: cnt=59
    bullet(300, 300, 2, 1'b0);
    tick();                            // N+1
    hit_now();
    tick();                            // N+2: hit while invulnerable
    checks++; if (player_hit !== 1'b1 || health !== 2'd2) begin failures++; $display("FAIL invuln_hit got=%b/%0d exp=1/2", player_hit, health); end
    bullet(300, 300, 2, 1'b0);
    for (int k = 3; k <= 59; k++) tick();
    checks++; if (invuln !== 1'b1) begin failures++; $display("FAIL invuln_before_expiry got=%b exp=1", invuln); end
    hit_now();
    tick();                            // N+60: expiry edge with a hit
    checks++; if (player_hit !== 1'b1 || health !== 2'd2 || invuln !== 1'b0) begin failures++; $display("FAIL invuln_expiry_hit got=%b/%0d/%b exp=1/2/0", player_hit, health, invuln); end
    bullet(300, 300, 2, 1'b0);
    tick();
    $display("invuln: health=%0d invuln=%b", health, invuln);
  endtask

  task automatic test_death();
    do_restart();
    for (int h = 2; h >= 0; h--) begin
      hit_now();
      tick();
      checks++; if (player_hit !== 1'b1 || health !== 2'(h)) begin failures++; $display("FAIL death_hit_%0d got=%b/%0d exp=1/%0d", h, player_hit, health, h); end
      bullet(300, 300, 2, 1'b0);
      for (int k = 0; k < 60; k++) tick();
    end
    checks++; if (player_dead !== 1'b1 || invuln !== 1'b0) begin failures++; $display("FAIL death_dead got=%b/%b exp=1/0", player_dead, invuln); end
    hit_now();
    armor_pickup = 1'b1;
    tick();
    armor_pickup = 1'b0;
    checks++; if (player_hit !== 1'b0 || armor_hit !== 1'b0 || health !== 2'd0) begin failures++; $display("FAIL death_passthru got=%b%b/%0d exp=00/0", player_hit, armor_hit, health); end
    checks++; if (armor_count !== 2'd0) begin failures++; $display("FAIL death_pickup got=%0d exp=0", armor_count); end
    do_restart();
    checks++; if (health !== 2'd3 || player_dead !== 1'b0) begin failures++; $display("FAIL death_restart got=%0d/%b exp=3/0", health, player_dead); end
    $display("death: health=%0d dead=%b", health, player_dead);
  endtask

  task automatic test_linger();
    int pulses;
    do_restart();
    pulses = 0;
    hit_now();
    for (int k = 0; k < 5; k++) begin
      tick();
      if (player_hit === 1'b1) pulses++;
    end
    bullet(300, 300, 2, 1'b0);
    tick();
    checks++; if (pulses != 1 || health !== 2'd2) begin failures++; $display("FAIL linger got=%0d/%0d exp=1/2", pulses, health); end
    $display("linger: pulses=%0d health=%0d", pulses, health);
  endtask

  task automatic test_pickup_with_hit();
    do_restart();
    hit_now();
    armor_pickup = 1'b1;
    tick();
    armor_pickup = 1'b0;
    checks++; if (player_hit !== 1'b1 || armor_hit !== 1'b0 || health !== 2'd2 || armor_count !== 2'd2) begin failures++; $display("FAIL pickhit_noarmor got=%b%b/%0d/%0d exp=10/2/2", player_hit, armor_hit, health, armor_count); end
    do_restart();
    armor_pickup = 1'b1;
    tick();
    hit_now();
    tick();
    armor_pickup = 1'b0;
    checks++; if (armor_hit !== 1'b1 || armor_count !== 2'd2 || health !== 2'd3) begin failures++; $display("FAIL pickhit_armor got=%b/%0d/%0d exp=1/2/3", armor_hit, armor_count, health); end
    $display("pickup_with_hit: armor=%0d", armor_count);
  endtask

  task automatic test_reset_mid();
    do_restart();
    hit_now();
    tick();                            // player_hit high, INVULN
    Reset_n = 1'b0;
    #1;
    checks++; if ({player_hit, armor_hit, invuln, player_dead} !== 4'b0000 || health !== 2'd3 || armor_count !== 2'd0) begin failures++; $display("FAIL reset_mid got=%b/%0d/%0d exp=0000/3/0", {player_hit, armor_hit, invuln, player_dead}, health, armor_count); end
    bullet(300, 300, 2, 1'b0);
    #1;
    Reset_n = 1'b1;
    tick();
    hit_now();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++; if (player_hit !== 1'b0 || health !== 2'd3 || invuln !== 1'b0) begin failures++; $display("FAIL restart_hit got=%b/%0d/%b exp=0/3/0", player_hit, health, invuln); end
    bullet(300, 300, 2, 1'b0);
    tick();
    $display("reset_mid: health=%0d", health);
  endtask

  initial begin
    checks = 0; failures = 0;
    Reset_n = 1'b0; restart = 1'b0; armor_pickup = 1'b0; bullet_upgraded = 1'b0;
    TankX = 10'd100; TankY = 10'd100; TankS = 10'd8;
    bullet(300, 300, 2, 1'b0);
    test_reset();
    test_approach();
    test_boundary();
    test_armor();
    test_invuln();
    test_death();
    test_linger();
    test_pickup_with_hit();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
